// File: rtl/fp21_add_pack_out.sv
// Output stage behind the pipelined FP21 adder.
// It tracks which adder slots carry real operations and selects special-operand
// results. It packs the unpacked adder result into a 21-bit word, with overflow,
// underflow and cancellation handling. Results are buffered in a first-word
// fall-through FIFO. The issuer is throttled by credit because the adder cannot stall.
module fp21_add_pack_out #(
    parameter int EXP_W   = 7,
    parameter int FRAC_W  = 13,
    parameter int BIAS    = 63,
    parameter int LATENCY = 11,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    issue_special,
    input  logic [EXP_W+FRAC_W:0]   issue_special_word,
    input  logic                    add_sign,
    input  logic [EXP_W+1:0]        add_exp,
    input  logic [FRAC_W:0]         add_frac,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_data,
    output logic [2:0]              out_flags
);
    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int E_W   = EXP_W + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [E_W-1:0] BIAS_S    = E_W'(BIAS);
    localparam logic signed [E_W-1:0] EXP_MAX_S = E_W'((1 << EXP_W) - 1);

    logic                 issue_fire;
    logic [LATENCY-1:0]   dl_vld_q, dl_vld_d;
    logic [LATENCY-1:0]   dl_spc_q, dl_spc_d;
    logic [W-1:0]         dl_word_q [LATENCY];
    logic [W-1:0]         dl_word_d [LATENCY];

    logic signed [E_W-1:0] biased;
    logic [W-1:0]         pk_word;
    logic [2:0]           pk_flags;
    logic                 pack_vld_q, pack_vld_d;
    logic [W-1:0]         pack_word_q, pack_word_d;
    logic [2:0]           pack_flags_q, pack_flags_d;

    logic [W+2:0]         mem_q [DEPTH];
    logic [W+2:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d, inflight_q, inflight_d;
    logic                 ready_en_q, ready_en_d;
    logic                 push, pop, full;

    // Credit: ready only once out of reset and while FIFO plus in-flight items leave room.
    always_comb begin
        issue_ready = ready_en_q &&
                      (({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W+1)'(DEPTH));
        issue_fire  = issue_valid & issue_ready;
    end

    // Delay line shifts slot validity and the special-operand override alongside the adder.
    always_comb begin
        dl_vld_d     = {dl_vld_q[LATENCY-2:0], issue_fire};
        dl_spc_d     = {dl_spc_q[LATENCY-2:0], issue_special & issue_fire};
        dl_word_d[0] = issue_special_word;
        for (int i = 1; i < LATENCY; i++) begin
            dl_word_d[i] = dl_word_q[i-1];
        end
    end

    // Pack the tap result; special beats cancellation, which beats exponent range handling.
    always_comb begin
        biased   = $signed(add_exp) + BIAS_S;
        pk_word  = '0;
        pk_flags = 3'b000;
        if (dl_spc_q[LATENCY-1]) begin
            pk_word  = dl_word_q[LATENCY-1];
            pk_flags = 3'b100;
        end else if (!add_frac[FRAC_W]) begin
            pk_word  = '0;
            pk_flags = 3'b000;
        end else if (biased >= EXP_MAX_S) begin
            pk_word  = {add_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            pk_flags = 3'b010;
        end else if (biased[E_W-1] || biased == '0) begin
            pk_word  = {add_sign, {(W-1){1'b0}}};
            pk_flags = 3'b001;
        end else begin
            pk_word  = {add_sign, biased[EXP_W-1:0], add_frac[FRAC_W-1:0]};
        end
        pack_vld_d   = dl_vld_q[LATENCY-1];
        pack_word_d  = dl_vld_q[LATENCY-1] ? pk_word  : pack_word_q;
        pack_flags_d = dl_vld_q[LATENCY-1] ? pk_flags : pack_flags_q;
    end

    // FIFO write/read pointers, occupancy and in-flight credit accounting.
    always_comb begin
        push       = pack_vld_q;
        out_valid  = (count_q != '0);
        pop        = out_valid & out_ready;
        full       = (count_q == CNT_W'(DEPTH));
        mem_d      = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {pack_flags_q, pack_word_q};
        end
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d = inflight_q + CNT_W'(issue_fire) - CNT_W'(push);
        ready_en_d = 1'b1;
        {out_flags, out_data} = mem_q[rd_ptr_q];
    end

    // All state clears on reset so in-flight work and buffered results are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_vld_q     <= '0;
            dl_spc_q     <= '0;
            for (int i = 0; i < LATENCY; i++) dl_word_q[i] <= '0;
            pack_vld_q   <= 1'b0;
            pack_word_q  <= '0;
            pack_flags_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            ready_en_q   <= 1'b0;
        end else begin
            dl_vld_q     <= dl_vld_d;
            dl_spc_q     <= dl_spc_d;
            dl_word_q    <= dl_word_d;
            pack_vld_q   <= pack_vld_d;
            pack_word_q  <= pack_word_d;
            pack_flags_q <= pack_flags_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            ready_en_q   <= ready_en_d;
        end
    end

    // Credit should make this unreachable: a push into a full FIFO needs a same-cycle pop.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule
